// File: rtl/mmio_store_pkg.sv
// Shared defaults and entry layout for the MMIO store port.
// STORE_TIMESTAMP_EN adds a capture-cycle stamp to each entry.
package mmio_store_pkg;

    localparam int          PKG_N         = 32;
    localparam int          PKG_DEPTH     = 8;
    localparam int          PKG_TS_W      = 16;
    localparam logic [31:0] PKG_OUT_ADDR  = 32'd84;
    localparam logic [31:0] PKG_HALT_ADDR = 32'd88;

    // Entry layout at default widths; the stamp sits above the data bits.
    typedef struct packed {
`ifdef STORE_TIMESTAMP_EN
        logic [PKG_TS_W-1:0] stamp;
`endif
        logic [PKG_N-1:0]    data;
    } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered-output FIFO, no fall-through; full+pop+push writes the freed slot.
// Storage is reset so the head reads zero out of reset.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    // When full, a same-edge pop frees the head slot, which is also the write slot.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mmio_store_port.sv
// Captures CPU stores to OUT_ADDR into a FIFO and flags a store to HALT_ADDR.
// Optional STORE_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module mmio_store_port
    import mmio_store_pkg::*;
#(
    parameter int           N         = PKG_N,
    parameter int           DEPTH     = PKG_DEPTH,
    parameter logic [N-1:0] OUT_ADDR  = N'(PKG_OUT_ADDR),
    parameter logic [N-1:0] HALT_ADDR = N'(PKG_HALT_ADDR),
    parameter int           TS_W      = PKG_TS_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [N-1:0]             dataadr,
    input  logic [N-1:0]             writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
`ifdef STORE_TIMESTAMP_EN
    output logic [TS_W-1:0]          out_stamp,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     drained
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (OUT_ADDR == HALT_ADDR) begin : g_bad_addr
        $error("mmio_store_port: OUT_ADDR and HALT_ADDR must differ");
    end
    if (TS_W < 1) begin : g_bad_ts
        $error("mmio_store_port: TS_W must be at least 1");
    end

`ifdef STORE_TIMESTAMP_EN
    localparam int ENTRY_W = N + TS_W;
    logic [TS_W-1:0] r_cycle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cycle <= '0;
        else        r_cycle <= r_cycle + TS_W'(1);
    end
`else
    localparam int ENTRY_W = N;
`endif

    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_halt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               r_done;
    logic               r_overflow;

    assign w_push = memwrite & (dataadr == OUT_ADDR);
    assign w_halt = memwrite & (dataadr == HALT_ADDR);
    assign w_pop  = out_valid & out_ready;

`ifdef STORE_TIMESTAMP_EN
    assign w_wr_entry = {r_cycle, writedata};
    assign out_stamp  = w_head[N +: TS_W];
`else
    assign w_wr_entry = writedata;
`endif

    sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Both flags are sticky until reset; a drop happens only when full with no pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_halt)                     r_done     <= 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_head[N-1:0];
    assign count     = w_count;
    assign overflow  = r_overflow;
    assign done      = r_done;
    assign drained   = r_done & w_empty;

endmodule

// File: tb/tb_mmio_store_port.sv
// Directed bench for mmio_store_port with a queue model of the FIFO contents.
// Define STORE_TIMESTAMP_EN to also exercise the capture stamps.
module tb_mmio_store_port;

    localparam logic [31:0] OUT_ADDR  = 32'd84;
    localparam logic [31:0] HALT_ADDR = 32'd88;
    localparam int          DEPTH     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef STORE_TIMESTAMP_EN
    logic [15:0] out_stamp;
`endif
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        drained;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic        exp_overflow;
    logic        exp_done;
    logic [31:0] last_word;

    always #5 clk = ~clk;

    mmio_store_port dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STORE_TIMESTAMP_EN
        .out_stamp (out_stamp),
`endif
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .drained   (drained)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus cycle: update the model for this edge, then drive and clock.
    task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bit pop;
        pop = out_ready && (exp_q.size() != 0);
        if (pop) last_word = exp_q.pop_front();
        if (we && addr == OUT_ADDR) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else                      exp_overflow = 1'b1;
        end
        if (we && addr == HALT_ADDR) exp_done = 1'b1;
        memwrite  = we;
        dataadr   = addr;
        writedata = data;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},    count,     64'(exp_q.size()));
        check({tag, ".valid"},    out_valid, 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, ".data"}, out_data, exp_q[0]);
        check({tag, ".overflow"}, overflow,  exp_overflow);
        check({tag, ".done"},     done,      exp_done);
        check({tag, ".drained"},  drained,   64'(exp_done && exp_q.size() == 0));
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_overflow = 1'b0;
        exp_done     = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (exp_q.size() == 0) break;
            check({tag, ".head"}, out_data, exp_q[0]);
            cycle(1'b0, 32'd0, 32'd0);
        end
        check({tag, ".empty_valid"}, out_valid, 1'b0);
        check({tag, ".empty_count"}, count, 4'd0);
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; out_ready = 1'b0;
        clear_model();
        last_word = '0;
        #3;
        check_state("rst");
        check("rst.data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Single store, one-cycle latency, then popped.
        out_ready = 1'b1;
        cycle(1'b1, OUT_ADDR, 32'h96);
        check("single.valid", out_valid, 1'b1);
        check("single.data", out_data, 32'h0000_0096);
        cycle(1'b0, 32'd0, 32'd0);
        check("single.after_valid", out_valid, 1'b0);
        check("single.after_count", count, 4'd0);

        // Fill, overflow with 9, drain 1..8 in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) cycle(1'b1, OUT_ADDR, 32'(i));
        check("fill.count", count, 4'd8);
        check("fill.overflow", overflow, 1'b0);
        cycle(1'b1, OUT_ADDR, 32'd9);
        check("ovf.overflow", overflow, 1'b1);
        check("ovf.count", count, 4'd8);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf.order", out_data, 32'(i));
            cycle(1'b0, 32'd0, 32'd0);
        end
        check("ovf.no_nine", out_valid, 1'b0);
        check_state("ovf.end");

        // Full with simultaneous push and pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) cycle(1'b1, OUT_ADDR, 32'(i));
        out_ready = 1'b1;
        cycle(1'b1, OUT_ADDR, 32'hA);
        check("fullpp.count", count, 4'd8);
        check("fullpp.overflow", overflow, 1'b0);
        check("fullpp.head", out_data, 32'd2);
        drain("fullpp");
        check("fullpp.last", last_word, 32'hA);

        // Address decode, halt and drained.
        cycle(1'b1, 32'd80, 32'h1);
        cycle(1'b1, 32'd92, 32'h2);
        cycle(1'b0, OUT_ADDR, 32'h3);
        check("decode.count", count, 4'd0);
        check("decode.valid", out_valid, 1'b0);
        cycle(1'b1, HALT_ADDR, 32'h55);
        check("halt.done", done, 1'b1);
        check("halt.drained", drained, 1'b1);
        check("halt.count", count, 4'd0);
        out_ready = 1'b0;
        cycle(1'b1, OUT_ADDR, 32'h11);
        cycle(1'b1, OUT_ADDR, 32'h22);
        check("pend.drained", drained, 1'b0);
        check("pend.count", count, 4'd2);
        out_ready = 1'b1;
        cycle(1'b0, 32'd0, 32'd0);
        check("pend1.drained", drained, 1'b0);
        check("pend1.head", out_data, 32'h22);
        cycle(1'b1, OUT_ADDR, 32'h33);
        check("one_pp.valid", out_valid, 1'b1);
        check("one_pp.head", out_data, 32'h33);
        check("one_pp.count", count, 4'd1);
        cycle(1'b0, 32'd0, 32'd0);
        check("last_pop.drained", drained, 1'b1);
        check_state("last_pop");

        // Asynchronous reset mid-cycle.
        out_ready = 1'b0;
        cycle(1'b1, OUT_ADDR, 32'h1);
        cycle(1'b1, OUT_ADDR, 32'h2);
        cycle(1'b1, OUT_ADDR, 32'h3);
        check("arst.pre_count", count, 4'd3);
        #2 reset = 1'b0;
        #1;
        check("arst.valid", out_valid, 1'b0);
        check("arst.count", count, 4'd0);
        check("arst.done", done, 1'b0);
        check("arst.overflow", overflow, 1'b0);
        check("arst.drained", drained, 1'b0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, OUT_ADDR, 32'h77);
        check("arst.recap_data", out_data, 32'h77);
        check("arst.recap_count", count, 4'd1);

`ifdef STORE_TIMESTAMP_EN
        do_reset();
        out_ready = 1'b0;
        repeat (5) cycle(1'b0, 32'd0, 32'd0);
        cycle(1'b1, OUT_ADDR, 32'hAA);
        repeat (6) cycle(1'b0, 32'd0, 32'd0);
        cycle(1'b1, OUT_ADDR, 32'hBB);
        check("stamp.first", out_stamp, 16'd5);
        out_ready = 1'b1;
        cycle(1'b0, 32'd0, 32'd0);
        check("stamp.second", out_stamp, 16'd12);
        check("stamp.second_data", out_data, 32'hBB);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmio_store_port.md
Name: mmio_store_port

Overview:
- Memory-mapped output peripheral on the computer's data-memory write bus (dataadr, writedata, memwrite).
- Captures CPU stores to a result address into a FIFO and drains them to a downstream consumer over a valid/ready handshake.
- Flags program completion when the CPU stores to a halt address.
- Gives benches and the board top a clean stream of program results instead of probing dmem.

Parameters:
- N, 32, data/address width of the CPU bus
- DEPTH, 8, FIFO entries; power of two, ≥2
- OUT_ADDR, 32'd84, store address whose data is queued
- HALT_ADDR, 32'd88, store address that raises done
- TS_W, 16, timestamp width; used only with STORE_TIMESTAMP_EN

Ports:
- clk  in  1  CPU clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memwrite  in  1  CPU store strobe
- dataadr  in  N  CPU store address
- writedata  in  N  CPU store data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  N  FIFO head data
- out_stamp  out  TS_W  capture cycle of head; present only with STORE_TIMESTAMP_EN
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a result store was dropped
- done  out  1  sticky: halt store seen
- drained  out  1  done & FIFO empty

Behaviour:
- Reset (reset low, async): FIFO empty, out_valid=0, out_data=0, count=0, overflow=0, done=0, drained=0, out_stamp=0, cycle counter=0. Reset asserted mid-operation discards all entries immediately.
- push = memwrite & (dataadr==OUT_ADDR). Sampled on the rising clk edge, i.e. the edge on which the single-cycle CPU commits the store.
- pop = out_valid & out_ready.
- No fall-through. A push into an empty FIFO gives out_valid=1 with out_data=writedata on the cycle after the edge (1-cycle latency).
- out_data and out_stamp are held stable while out_valid=1 and out_ready=0.
- Push is accepted if count<DEPTH, or if count==DEPTH and pop occurs on the same edge. Full with simultaneous push and pop: count stays DEPTH and the new word enters at the tail.
- Push rejected when full without pop: word dropped, overflow set, FIFO unchanged.
- Simultaneous push and pop when count==1: head advances to the new word, out_valid stays 1.
- out_ready while empty has no effect.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count carries full/empty distinction.
- memwrite with any other address is ignored, including X-free addresses beyond the window.
- Halt: memwrite & (dataadr==HALT_ADDR) sets done on that edge. The halt store's data is not queued.
- done and overflow clear only on reset.
- drained = done & (count==0), combinational.
- OUT_ADDR==HALT_ADDR is illegal; flagged by an elaboration-time check.

Optional Feature:
- Macro STORE_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit free-running cycle counter runs from reset, wrapping to 0 after all-ones.
  - Each entry stores the counter value at its push edge alongside data.
  - out_stamp presents the head entry's stamp.
- Undefined: no counter, no stamp storage, no out_stamp port. All other behaviour is identical.

Decomposition:
- Package mmio_store_pkg: default OUT_ADDR/HALT_ADDR constants and DEPTH default, plus a packed entry typedef (data, and stamp under STORE_TIMESTAMP_EN).
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty/count, same async active-low reset).
- mmio_store_port holds address decode, sticky flags, timestamp counter.

Test Plan:
- Reset then single store 0x96 to addr 84 with out_ready=1 → next cycle out_valid=1, out_data=0x00000096. Following cycle out_valid=0, count=0.
- out_ready=0, stores 1..8 to addr 84 → count=8. Ninth store 9 → overflow=1, count=8. Then out_ready=1 → data 1..8 in order; 9 never appears.
- FIFO full, store 0xA on the same edge as a pop → count stays 8, overflow stays 0, 0xA is the last word out.
- Stores to addr 80 and 92 plus memwrite=0 with dataadr=84 → no push, count=0. Store to 88 → done=1 next cycle, drained=1 while empty. With entries pending, drained=0 until the last pop.
- Three entries queued, assert reset low mid-cycle → out_valid, count, done, overflow all 0 immediately, without waiting for clk. After release the next store is captured normally.
- STORE_TIMESTAMP_EN defined, stores at cycles 5 and 12 after reset release → out_stamp 5 then 12. With TS_W=4, store at cycle 17 → stamp 1.
